// File: rtl/apb_cmd_master.sv
// APB3 master: turns a valid/ready command stream into one APB transfer per
// command and reports completion with a single-cycle response pulse carrying
// read data, slave error and timeout status.
module apb_cmd_master #(
    parameter int unsigned AWIDTH  = 4,
    parameter int unsigned DWIDTH  = 8,
    // Max consecutive ACCESS cycles with pready low before abort; 0 disables.
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              pclk,
    input  logic              presetn,

    // Command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,

    // Response pulse
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    // APB3 master interface
    output logic              psel,
    output logic              penable,
    output logic [AWIDTH-1:0] paddr,
    output logic              pwrite,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    // Wait counter is wide enough to hold TIMEOUT-1; at least one bit.
    localparam int unsigned CntW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit TimeoutEn = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;

    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic              timeout_hit;

    // This ACCESS cycle is the TIMEOUT-th consecutive one with pready low.
    assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

    // Next-state and registered-output logic for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = StSetup;
                end
            end

            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = StAccess;
            end

            StAccess: begin
                if (pready) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    state_d       = StIdle;
                end else if (timeout_hit) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                    state_d       = StIdle;
                end else if (cnt_q != {CntW{1'b1}}) begin
                    // Saturate when the timeout is disabled so the count never wraps.
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer without a response.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == StIdle);

    assign psel        = psel_q;
    assign penable     = penable_q;
    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule
